// File: rtl/pcie_req_arbiter_if.sv
// pcie_req_arbiter_if: requester and PCIe mailbox handshake bundle for pcie_req_arbiter.
interface pcie_req_arbiter_if;
  logic        fmReq;
  logic [15:0] fmData;
  logic [31:0] fmAddr;
  logic        fmAck;
  logic        knReq;
  logic        knNumber;
  logic        knAck;
  logic        writeFM;
  logic [15:0] writeFMData;
  logic [31:0] writeFMAddr;
  logic        writeFMDone;
  logic        updataKernel;
  logic        updataKernelNumber;
  logic        updataKernelDone;
  logic        arbBusy;
  logic        arbTimeout;
  modport slave (
    input  fmReq, fmData, fmAddr, knReq, knNumber, writeFMDone, updataKernelDone,
    output fmAck, knAck, writeFM, writeFMData, writeFMAddr, updataKernel, updataKernelNumber,
           arbBusy, arbTimeout
  );
  modport master (
    output fmReq, fmData, fmAddr, knReq, knNumber, writeFMDone, updataKernelDone,
    input  fmAck, knAck, writeFM, writeFMData, writeFMAddr, updataKernel, updataKernelNumber,
           arbBusy, arbTimeout
  );
endinterface

// File: rtl/pcie_req_arbiter.sv
// pcie_req_arbiter: round-robin FM-write / kernel-update arbiter with four-phase done handshake.
// Define PCIE_ARB_TIMEOUT_EN to abort a grant whose done never arrives within TIMEOUT_CYCLES.
module pcie_req_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic             pcieArbClk,
  input logic             pcieArbRst,
  pcie_req_arbiter_if.slave io_arb
);
  typedef enum logic [2:0] {IDLE, FM_BUSY, FM_REL, KN_BUSY, KN_REL} state_t;
  state_t      r_state, w_next;
  logic        r_last_kn, r_fm_ack, r_kn_ack, r_fm_done_q, r_kn_done_q, r_kn_num;
  logic [15:0] r_data;
  logic [31:0] r_addr;
  logic        w_fm_go, w_kn_go, w_to, w_pick_fm;
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 2..65535");
  end
  // only a fresh low-to-high done completes a grant, so a done left high from before is never taken
  assign w_fm_go   = io_arb.writeFMDone && !r_fm_done_q;
  assign w_kn_go   = io_arb.updataKernelDone && !r_kn_done_q;
  assign w_pick_fm = io_arb.fmReq && (!io_arb.knReq || r_last_kn);
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_pick_fm ? FM_BUSY : io_arb.knReq ? KN_BUSY : IDLE;
      FM_BUSY: w_next = w_fm_go ? FM_REL : w_to ? IDLE : FM_BUSY;
      FM_REL:  w_next = io_arb.writeFMDone ? FM_REL : IDLE;
      KN_BUSY: w_next = w_kn_go ? KN_REL : w_to ? IDLE : KN_BUSY;
      KN_REL:  w_next = io_arb.updataKernelDone ? KN_REL : IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge pcieArbClk) begin
    if (!pcieArbRst) begin
      r_state     <= IDLE;
      r_last_kn   <= 1'b1;
      r_fm_ack    <= 1'b0;
      r_kn_ack    <= 1'b0;
      r_fm_done_q <= 1'b0;
      r_kn_done_q <= 1'b0;
      r_kn_num    <= 1'b0;
      r_data      <= '0;
      r_addr      <= '0;
    end else begin
      r_state     <= w_next;
      r_fm_done_q <= io_arb.writeFMDone;
      r_kn_done_q <= io_arb.updataKernelDone;
      r_fm_ack    <= r_state == FM_BUSY && w_next != FM_BUSY;
      r_kn_ack    <= r_state == KN_BUSY && w_next != KN_BUSY;
      if (r_state == IDLE && w_next == FM_BUSY) begin
        r_data    <= io_arb.fmData;
        r_addr    <= io_arb.fmAddr;
        r_last_kn <= 1'b0;
      end
      if (r_state == IDLE && w_next == KN_BUSY) begin
        r_kn_num  <= io_arb.knNumber;
        r_last_kn <= 1'b1;
      end
    end
  end
`ifdef PCIE_ARB_TIMEOUT_EN
  logic [15:0] r_cnt;
  logic        r_timeout;
  logic        w_busy;
  assign w_busy = r_state == FM_BUSY || r_state == KN_BUSY;
  assign w_to   = r_cnt == 16'(TIMEOUT_CYCLES - 1);
  // the counter sits at zero outside a busy phase, so each grant starts its own count
  always_ff @(posedge pcieArbClk) begin
    if (!pcieArbRst) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_cnt     <= w_busy ? r_cnt + 16'd1 : '0;
      r_timeout <= r_timeout || (w_busy && w_next == IDLE);
    end
  end
  assign io_arb.arbTimeout = r_timeout;
`else
  assign w_to              = 1'b0;
  assign io_arb.arbTimeout = 1'b0;
`endif
  assign io_arb.writeFM            = r_state == FM_BUSY;
  assign io_arb.updataKernel       = r_state == KN_BUSY;
  assign io_arb.writeFMData        = r_data;
  assign io_arb.writeFMAddr        = r_addr;
  assign io_arb.updataKernelNumber = r_kn_num;
  assign io_arb.fmAck              = r_fm_ack;
  assign io_arb.knAck              = r_kn_ack;
  assign io_arb.arbBusy            = r_state != IDLE;
endmodule

// File: tb/tb_pcie_req_arbiter.sv
// tb_pcie_req_arbiter: directed bench for pcie_req_arbiter with a transaction-level reference model.
module tb_pcie_req_arbiter;
  localparam int TO = 8;
`ifdef PCIE_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  pcie_req_arbiter_if ifc();
  pcie_req_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .pcieArbClk(clk),
    .pcieArbRst(rst),
    .io_arb(ifc)
  );
  always #5 clk = ~clk;
  // owner: 0 nobody, 1 FM, 2 kernel; rel marks the post-ack wait for done to fall
  typedef struct packed {
    logic [1:0]  owner;
    logic        rel;
    logic        last_kn;
    logic [15:0] age;
    logic        fm_ack;
    logic        kn_ack;
    logic [15:0] data;
    logic [31:0] addr;
    logic        num;
    logic        tmo;
    logic        pfd;
    logic        pkd;
  } model_t;
  function automatic model_t step(input model_t s, input logic rn, input logic fr, input logic kr,
                                  input logic fd, input logic kd, input logic [15:0] d,
                                  input logic [31:0] a, input logic n);
    model_t m;
    m = s;
    m.fm_ack = 1'b0;
    m.kn_ack = 1'b0;
    if (!rn) begin
      m = '0;
      m.last_kn = 1'b1;
      return m;
    end
    if (s.owner == 2'd0) begin
      if (fr && (!kr || s.last_kn)) begin
        m.owner = 2'd1; m.data = d; m.addr = a; m.last_kn = 1'b0;
      end else if (kr) begin
        m.owner = 2'd2; m.num = n; m.last_kn = 1'b1;
      end
      m.rel = 1'b0;
      m.age = '0;
    end else if (s.rel) begin
      if (!(s.owner == 2'd1 ? fd : kd)) m.owner = 2'd0;
    end else if (s.owner == 2'd1 ? (fd && !s.pfd) : (kd && !s.pkd)) begin
      m.rel = 1'b1;
      if (s.owner == 2'd1) m.fm_ack = 1'b1; else m.kn_ack = 1'b1;
    end else begin
      m.age = s.age + 16'd1;
      if (TO_EN && m.age == 16'(TO)) begin
        if (s.owner == 2'd1) m.fm_ack = 1'b1; else m.kn_ack = 1'b1;
        m.tmo   = 1'b1;
        m.owner = 2'd0;
      end
    end
    m.pfd = fd;
    m.pkd = kd;
    return m;
  endfunction
  model_t m = '0;
  always @(posedge clk)
    m <= step(m, rst, ifc.fmReq, ifc.knReq, ifc.writeFMDone, ifc.updataKernelDone,
              ifc.fmData, ifc.fmAddr, ifc.knNumber);
  int checks = 0;
  int errors = 0;
  int fm_acks = 0;
  int kn_acks = 0;
  bit chk_en = 1'b0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic rst_pulse();
    @(negedge clk);
    rst = 1'b0;
    ifc.fmReq = 1'b0; ifc.knReq = 1'b0; ifc.knNumber = 1'b0;
    ifc.fmData = '0; ifc.fmAddr = '0;
    ifc.writeFMDone = 1'b0; ifc.updataKernelDone = 1'b0;
    cyc(2);
    rst = 1'b1;
  endtask
  task automatic wait_for(input int which, input string nm);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(negedge clk);
      seen = which == 0 ? ifc.fmAck : which == 1 ? ifc.knAck : which == 2 ? ifc.writeFM : ifc.updataKernel;
    end
    chk(nm, 32'(seen), 32'd1);
  endtask
  initial begin
    fork
      forever begin
        @(negedge clk);
        if (ifc.fmAck) fm_acks++;
        if (ifc.knAck) kn_acks++;
        if (chk_en) begin
          chk("writeFM",            32'(ifc.writeFM),            32'(m.owner == 2'd1 && !m.rel));
          chk("updataKernel",       32'(ifc.updataKernel),       32'(m.owner == 2'd2 && !m.rel));
          chk("fmAck",              32'(ifc.fmAck),              32'(m.fm_ack));
          chk("knAck",              32'(ifc.knAck),              32'(m.kn_ack));
          chk("writeFMData",        32'(ifc.writeFMData),        32'(m.data));
          chk("writeFMAddr",        ifc.writeFMAddr,             m.addr);
          chk("updataKernelNumber", 32'(ifc.updataKernelNumber), 32'(m.num));
          chk("arbBusy",            32'(ifc.arbBusy),            32'(m.owner != 2'd0));
          chk("arbTimeout",         32'(ifc.arbTimeout),         32'(m.tmo));
        end
      end
      begin
        int base, hi;
        bit seen;
        ifc.fmReq = 1'b0; ifc.knReq = 1'b0; ifc.knNumber = 1'b0;
        ifc.fmData = '0; ifc.fmAddr = '0;
        ifc.writeFMDone = 1'b0; ifc.updataKernelDone = 1'b0;
        rst_pulse();
        chk_en = 1'b1;
        chk("rst_writeFM", 32'(ifc.writeFM), 32'd0);
        chk("rst_busy", 32'(ifc.arbBusy), 32'd0);
        chk("rst_data", 32'(ifc.writeFMData), 32'd0);
        chk("rst_timeout", 32'(ifc.arbTimeout), 32'd0);
        // single FM write, done five cycles after the request
        ifc.fmReq = 1'b1; ifc.fmData = 16'hA5A5; ifc.fmAddr = 32'h0000_1000;
        cyc(1);
        chk("fm_cmd", 32'(ifc.writeFM), 32'd1);
        chk("fm_data", 32'(ifc.writeFMData), 32'h0000_A5A5);
        chk("fm_addr", ifc.writeFMAddr, 32'h0000_1000);
        cyc(4);
        ifc.writeFMDone = 1'b1;
        wait_for(0, "fm_ack");
        ifc.fmReq = 1'b0; ifc.writeFMDone = 1'b0;
        cyc(1);
        chk("fm_idle", 32'(ifc.arbBusy), 32'd0);
        chk("fm_ack_cnt", 32'(fm_acks), 32'd1);
        // simultaneous requests: FM first after reset, then kernel wins the re-request tie
        rst_pulse();
        ifc.fmReq = 1'b1; ifc.knReq = 1'b1; ifc.knNumber = 1'b1;
        ifc.fmData = 16'h1234; ifc.fmAddr = 32'hDEAD_BEEF;
        cyc(1);
        chk("tie1_fm", 32'(ifc.writeFM), 32'd1);
        chk("tie1_kn", 32'(ifc.updataKernel), 32'd0);
        ifc.writeFMDone = 1'b1;
        wait_for(0, "tie1_fm_ack");
        ifc.fmReq = 1'b0; ifc.writeFMDone = 1'b0;
        ifc.fmData = 16'h5555; ifc.fmAddr = 32'h0000_3000;
        cyc(1);
        ifc.fmReq = 1'b1;
        cyc(1);
        chk("tie2_kn", 32'(ifc.updataKernel), 32'd1);
        chk("tie2_fm", 32'(ifc.writeFM), 32'd0);
        chk("tie2_num", 32'(ifc.updataKernelNumber), 32'd1);
        ifc.updataKernelDone = 1'b1;
        wait_for(1, "tie2_kn_ack");
        ifc.knReq = 1'b0; ifc.updataKernelDone = 1'b0;
        wait_for(2, "tie2_fm_cmd");
        chk("tie2_fm_data", 32'(ifc.writeFMData), 32'h0000_5555);
        chk("tie2_fm_addr", ifc.writeFMAddr, 32'h0000_3000);
        ifc.writeFMDone = 1'b1;
        wait_for(0, "tie2_fm_ack");
        ifc.fmReq = 1'b0; ifc.writeFMDone = 1'b0;
        cyc(1);
        // done already high before the request must not complete the grant
        rst_pulse();
        ifc.writeFMDone = 1'b1;
        cyc(1);
        base = fm_acks;
        ifc.fmReq = 1'b1; ifc.fmData = 16'h0F0F; ifc.fmAddr = 32'h0000_2000;
        cyc(4);
        chk("stale_no_ack", 32'(fm_acks), 32'(base));
        chk("stale_cmd", 32'(ifc.writeFM), 32'd1);
        ifc.writeFMDone = 1'b0;
        cyc(2);
        ifc.writeFMDone = 1'b1;
        wait_for(0, "stale_ack");
        ifc.fmReq = 1'b0; ifc.knReq = 1'b1; ifc.knNumber = 1'b0;
        cyc(3);
        chk("rel_hold_kn", 32'(ifc.updataKernel), 32'd0);
        chk("rel_busy", 32'(ifc.arbBusy), 32'd1);
        chk("stale_ack_cnt", 32'(fm_acks), 32'(base + 1));
        ifc.writeFMDone = 1'b0;
        wait_for(3, "rel_kn_cmd");
        chk("rel_kn_num", 32'(ifc.updataKernelNumber), 32'd0);
        ifc.updataKernelDone = 1'b1;
        wait_for(1, "rel_kn_ack");
        ifc.knReq = 1'b0; ifc.updataKernelDone = 1'b0;
        cyc(1);
        // reset in the middle of a kernel grant
        rst_pulse();
        ifc.knReq = 1'b1; ifc.knNumber = 1'b1;
        cyc(1);
        chk("mid_kn_cmd", 32'(ifc.updataKernel), 32'd1);
        base = kn_acks;
        rst = 1'b0;
        cyc(1);
        chk("mid_kn_low", 32'(ifc.updataKernel), 32'd0);
        chk("mid_busy", 32'(ifc.arbBusy), 32'd0);
        chk("mid_num", 32'(ifc.updataKernelNumber), 32'd0);
        chk("mid_ack", 32'(ifc.knAck), 32'd0);
        ifc.knReq = 1'b0;
        cyc(2);
        rst = 1'b1;
        cyc(3);
        chk("mid_no_ack", 32'(kn_acks), 32'(base));
        // kernel grant whose done never arrives
        rst_pulse();
        ifc.knReq = 1'b1; ifc.knNumber = 1'b1;
        hi = 0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
          @(negedge clk);
          hi += int'(ifc.updataKernel);
          seen = ifc.knAck;
        end
`ifdef PCIE_ARB_TIMEOUT_EN
        ifc.knReq = 1'b0;
        chk("to_ack", 32'(seen), 32'd1);
        chk("to_cycles", 32'(hi), 32'd8);
        chk("to_flag", 32'(ifc.arbTimeout), 32'd1);
        cyc(3);
        chk("to_sticky", 32'(ifc.arbTimeout), 32'd1);
        chk("to_cmd_low", 32'(ifc.updataKernel), 32'd0);
`else
        chk("to_none", 32'(seen), 32'd0);
        chk("to_cycles", 32'(hi), 32'd20);
        chk("to_flag", 32'(ifc.arbTimeout), 32'd0);
        chk("to_cmd_high", 32'(ifc.updataKernel), 32'd1);
        ifc.knReq = 1'b0;
`endif
        cyc(2);
      end
    join_any
    disable fork;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pcie_req_arbiter.md
PCIE_REQ_ARBITER -- requirements
Module: pcie_req_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024: max cycles a grant waits for its done signal (16-bit counter, legal 2..65535).
REQ-002 pcieArbClk  in  1  sole clock, all logic on rising edge.
REQ-003 pcieArbRst  in  1  reset, synchronous, active-low.
REQ-004 fmReq  in  1  FM-write requester: level request, held until fmAck.
REQ-005 fmData  in  16  FM write data, stable while fmReq high.
REQ-006 fmAddr  in  32  FM write address, stable while fmReq high.
REQ-007 fmAck  out  1  one-cycle pulse: FM request completed.
REQ-008 knReq  in  1  kernel-update requester: level request, held until knAck.
REQ-009 knNumber  in  1  kernel buffer select (0/1), stable while knReq high.
REQ-010 knAck  out  1  one-cycle pulse: kernel request completed.
REQ-011 writeFM  out  1  FM-write command level toward PCIe mailbox.
REQ-012 writeFMData  out  16  latched FM data.
REQ-013 writeFMAddr  out  32  latched FM address.
REQ-014 writeFMDone  in  1  host done flag for FM write (level).
REQ-015 updataKernel  out  1  kernel-update command level toward PCIe mailbox.
REQ-016 updataKernelNumber  out  1  latched kernel select.
REQ-017 updataKernelDone  in  1  host done flag for kernel update (level).
REQ-018 arbBusy  out  1  high whenever FSM is not IDLE.
REQ-019 arbTimeout  out  1  sticky timeout error flag.

Function
REQ-020 FSM states SHALL be IDLE, FM_BUSY, FM_REL, KN_BUSY, KN_REL; only one command (writeFM or updataKernel) SHALL ever be high.
REQ-021 IDLE: fmReq only -> FM_BUSY; knReq only -> KN_BUSY; both -> grant the requester not served last (round-robin pointer lastGrant, reset value KN so FM wins first tie).
REQ-022 On the IDLE->x_BUSY transition the request payload SHALL be latched into writeFMData/writeFMAddr or updataKernelNumber; lastGrant updated at the same edge.
REQ-023 Latency: request sampled high in IDLE at edge N -> command output high after edge N+1... i.e. visible in cycle N+1.
REQ-024 x_BUSY: command held high; on sampling its done input high -> x_REL; command low and xAck pulses high for exactly the first x_REL cycle.
REQ-025 x_REL: wait until its done input sampled low (four-phase handshake), then -> IDLE; no new grant issued from x_REL.
REQ-026 Done inputs SHALL be ignored in IDLE and in the other requester's states (stale done never produces an ack).
REQ-027 Payload outputs SHALL hold their last latched value outside grants; unused payload bits never change.
REQ-028 Requester SHALL drop req within one cycle after its ack; a req still high in IDLE is a new request.
REQ-029 Simultaneous req of the just-served requester and the other in IDLE -> the other wins.

Reset
REQ-030 While pcieArbRst low at a rising edge: state IDLE, lastGrant=KN, all outputs 0, timeout counter 0, arbTimeout 0.
REQ-031 Reset mid-grant SHALL abort immediately with command deasserted and no ack.

Configuration
REQ-032 Macro PCIE_ARB_TIMEOUT_EN defined: counter clears on entering x_BUSY, increments each x_BUSY cycle; when it reaches TIMEOUT_CYCLES with done still low -> command low, xAck pulse, arbTimeout set (sticky until reset), FSM -> IDLE directly.
REQ-033 Macro undefined: no counter logic, x_BUSY waits indefinitely, arbTimeout tied 0.

Verification
REQ-034 fmReq=1, fmData=16'hA5A5, fmAddr=32'h0000_1000; writeFMDone high 5 cycles later -> writeFM high cycle after req, data/addr match, fmAck one pulse, arbBusy low after done drops.
REQ-035 fmReq and knReq rise same cycle after reset -> FM served first, then kernel with updataKernelNumber=knNumber; next simultaneous pair -> kernel first.
REQ-036 writeFMDone held high from before fmReq -> ack only after done sampled low then high again; no early fmAck (stale-done case via REL wait and IDLE ignore).
REQ-037 pcieArbRst low during KN_BUSY -> updataKernel low next cycle, knAck never pulses, all outputs 0.
REQ-038 PCIE_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, knReq with done never asserted -> updataKernel low and knAck pulse after 8 KN_BUSY cycles, arbTimeout=1 and stays 1; without macro -> updataKernel stays high, arbTimeout=0.
